// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a length-prefixed, XOR-checksummed instruction image from a
//   valid/ready byte stream into instruction memory, then releases the core
//   from reset once the whole image has been written and verified.
//
//   Stream: LEN[7:0], LEN[15:8], 4*LEN data bytes (little-endian words),
//   then one checksum byte equal to the XOR of all data bytes.
//
// Ports
//   clk          core clock, rising edge
//   reset        asynchronous active-high reset
//   start        one-cycle pulse that begins a load (from IDLE/DONE/ERROR)
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle
//   im_we        instruction memory write strobe, one cycle per word
//   im_waddr     byte address of the write (word_index*4)
//   im_wdata     instruction word being written
//   core_reset   processor reset, low only after a verified load
//   done         image loaded and verified
//   error        load failed
//   err_code     01 = length too large, 10 = checksum mismatch
//   words_loaded words written during the current load
module imem_boot_loader #(
  parameter int IMEM_DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [63:0] im_waddr,
  output logic [31:0] im_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(IMEM_DEPTH_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [23:0] word_lo;   // lower three bytes; the fourth arrives with the write
  logic [7:0]  chk_xor;
  logic        hs;

  // Ready is a pure decode of the state register, so reset drops it at once.
  assign in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == CHECK);
  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      word_lo      <= '0;
      chk_xor      <= '0;
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= '0;
            chk_xor      <= '0;
          end
        end
        LEN_LO: begin
          if (hs) begin
            len[7:0] <= in_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (hs) begin
            len[15:8] <= in_data;
            if ({in_data, len[7:0]} > MAX_LEN) begin
              state    <= ERROR;
              error    <= 1'b1;
              err_code <= 2'b01;
            end else if ({in_data, len[7:0]} == 16'd0) begin
              state <= CHECK;
            end else begin
              state    <= DATA;
              byte_cnt <= '0;
              word_idx <= '0;
            end
          end
        end
        DATA: begin
          if (hs) begin
            chk_xor  <= chk_xor ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_lo[7:0]   <= in_data;
              2'd1: word_lo[15:8]  <= in_data;
              2'd2: word_lo[23:16] <= in_data;
              default: begin
                // Word complete: write strobe is registered, so it lands
                // one cycle after the completing byte.
                im_we        <= 1'b1;
                im_wdata     <= {in_data, word_lo};
                im_waddr     <= {46'd0, word_idx, 2'b00};
                words_loaded <= words_loaded + 16'd1;
                word_idx     <= word_idx + 16'd1;
                if (word_idx == len - 16'd1) state <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
          if (hs) begin
            if (in_data == chk_xor) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state    <= ERROR;
              error    <= 1'b1;
              err_code <= 2'b10;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [63:0] im_waddr;
  logic [31:0] im_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  imem_boot_loader #(.IMEM_DEPTH_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .im_we(im_we),
    .im_waddr(im_waddr), .im_wdata(im_wdata), .core_reset(core_reset),
    .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  passed = 0;
  int  cyc = 0;
  int  last_hs = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write and
  // appear in the cycle right after the completing byte handshake.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", im_waddr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", im_waddr, e.addr);
        check("write_data", {32'd0, im_wdata}, {32'd0, e.data});
        check("write_latency", 64'(cyc), 64'(last_hs));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      total++;
      $display("FAIL byte_timeout: got no handshake for byte 0x%0h expected one within 20 cycles", b);
    end
    last_hs = cyc;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #0;
  endtask

  logic [7:0] normal_img [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                  8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};

  task automatic push_normal_writes();
    exp_q.push_back('{addr: 64'd0, data: 32'h00500013});
    exp_q.push_back('{addr: 64'd4, data: 32'h00A00093});
  endtask

  task automatic check_queue_empty(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_done_ok(input string tag, input logic [15:0] nwords);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(nwords));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_waddr", im_waddr, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // Normal load
    push_normal_writes();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(normal_img[i], 0);
    check_done_ok("normal", 16'd2);
    check_queue_empty("normal_writes");

    // Bad checksum
    push_normal_writes();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(normal_img[i], 0);
    send_byte(8'h71, 0);
    check("badck_error", 64'(error), 64'd1);
    check("badck_err_code", 64'(err_code), 64'd2);
    check("badck_core_reset", 64'(core_reset), 64'd1);
    check("badck_done", 64'(done), 64'd0);
    check("badck_words", 64'(words_loaded), 64'd2);
    check_queue_empty("badck_writes");

    // Oversize length: 65 words
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    check("big_error", 64'(error), 64'd1);
    check("big_err_code", 64'(err_code), 64'd1);
    check("big_in_ready", 64'(in_ready), 64'd0);
    check("big_core_reset", 64'(core_reset), 64'd1);
    // A byte offered in ERROR must not be taken.
    in_data = 8'h55; in_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("big_in_ready_hold", 64'(in_ready), 64'd0);
    check("big_words", 64'(words_loaded), 64'd0);
    in_valid = 1'b0;

    // Zero length then reload
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_done_ok("zero", 16'd0);
    pulse_start();
    check("reload_core_reset", 64'(core_reset), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    check("reload_in_ready", 64'(in_ready), 64'd1);

    // Stalled source with start pulsed mid-DATA (already in LEN_LO)
    push_normal_writes();
    for (int i = 0; i < 11; i++) begin
      send_byte(normal_img[i], 3);
      if (i == 5) pulse_start();
    end
    check_done_ok("stall", 16'd2);
    check_queue_empty("stall_writes");

    // Async reset right after the 6th byte; the pending write is dropped.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(normal_img[i], 0);
    reset = 1'b1;
    #1;
    check("amid_core_reset", 64'(core_reset), 64'd1);
    check("amid_in_ready", 64'(in_ready), 64'd0);
    check("amid_we", 64'(im_we), 64'd0);
    check("amid_words", 64'(words_loaded), 64'd0);
    check("amid_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push_normal_writes();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(normal_img[i], 0);
    check_done_ok("after_rst", 16'd2);
    repeat (3) @(posedge clk);
    check_queue_empty("after_rst_writes");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the single-cycle RISC-V core.
- Receives a length-prefixed, checksummed instruction image over a valid/ready byte interface.
- Assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port.
- Holds the core in reset (core_reset) until a complete image with a good checksum has been loaded.

Parameters:
- IMEM_DEPTH_WORDS, 64: instruction memory capacity in 32-bit words; maximum accepted length.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_waddr  output  64  byte address of the write, equal to word_index*4.
- im_wdata  output  32  instruction word being written.
- core_reset  output  1  reset to the processor; 1 until load succeeds.
- done  output  1  image loaded and verified.
- error  output  1  load failed.
- err_code  output  2  01 = length exceeds IMEM_DEPTH_WORDS; 10 = checksum mismatch; 00 otherwise.
- words_loaded  output  16  number of words written in the current load.

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=0, im_we=0, im_waddr=0, im_wdata=0, core_reset=1, done=0, error=0, err_code=00, words_loaded=0, internal len/byte_cnt/xor cleared.
- Handshake: a byte is consumed only on a clk edge with in_valid & in_ready. The source holds in_data stable while in_valid=1 and in_ready=0. There is no memory backpressure.
- Stream format: LEN[7:0], LEN[15:8], then 4*LEN data bytes (each word LSB first), then 1 checksum byte equal to the XOR of all data bytes only.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE: in_ready=0. start -> LEN_LO; clear done, error, err_code, words_loaded, and xor.
- LEN_LO: in_ready=1. Handshake -> latch len[7:0] and go to LEN_HI.
- LEN_HI: in_ready=1. Handshake -> latch len[15:8], then:
  - full len > IMEM_DEPTH_WORDS -> ERROR, err_code=01.
  - len == 0 -> CHECK.
  - otherwise -> DATA with byte_cnt=0 and word_idx=0.
- DATA: in_ready=1. Each handshake shifts the byte into the word at byte lane byte_cnt, XORs it into xor, and increments byte_cnt mod 4.
- Word write: on the 4th byte handshake, the next cycle has im_we=1 for exactly one cycle, with im_wdata = the assembled word, im_waddr = word_idx*4, and words_loaded incremented. Then word_idx increments.
- Write latency is 1 cycle after the completing byte. im_waddr and im_wdata hold their last values when im_we=0.
- After the handshake that completes word len-1 -> CHECK. The final im_we pulse overlaps the first CHECK cycle.
- CHECK: in_ready=1. On handshake, byte == xor -> DONE; otherwise -> ERROR with err_code=10.
- DONE: in_ready=0, done=1, core_reset=0 (deasserts on the first DONE cycle). start -> LEN_LO, and core_reset returns to 1 the next cycle.
- ERROR: in_ready=0, error=1, core_reset=1, err_code held. start -> LEN_LO.
- start in LEN_LO, LEN_HI, DATA, or CHECK: ignored; the load continues.
- Bytes presented in IDLE, DONE, or ERROR are not consumed.
- Failed loads: words already written stay in memory. The core never leaves reset on a failed load.
- Reset mid-load: immediate return to reset values. Partial memory contents are not cleared, and a new start is required.
- In-flight im_we pulse: reset forces it to 0, so that write may be lost.
- Length arithmetic: the length is 16-bit unsigned. word_idx is 16-bit internally, and im_waddr is zero-extended from word_idx*4.

Test Plan:
- Normal load:
  - Stimulus: start; bytes 02 00 13 00 50 00 93 00 A0 00 70.
  - Response: im_we at addr 0 with 0x00500013, then addr 4 with 0x00A00093, each 1 cycle after the 4th byte; done=1, core_reset=0, words_loaded=2, error=0.
- Bad checksum:
  - Stimulus: same stream with last byte 71.
  - Response: both writes occur; error=1, err_code=10, core_reset=1, done=0.
- Oversize length:
  - Stimulus: start; bytes 41 00 (65 > 64).
  - Response: ERROR after the 2nd byte, err_code=01, in_ready=0, no im_we pulse.
- Zero length, then reload:
  - Stimulus: start; bytes 00 00 00.
  - Response: DONE with no writes and core_reset=0.
  - Stimulus: start again.
  - Response: core_reset=1 the next cycle.
- Stalled source and ignored start:
  - Stimulus: normal load with in_valid low for 3 cycles between every byte; start pulsed mid-DATA.
  - Response: same writes and results as the normal load; start has no effect.
- Async reset mid-load:
  - Stimulus: assert reset after the 6th byte of the normal load.
  - Response: all outputs immediately at reset values (core_reset=1, in_ready=0); a subsequent full normal load succeeds.
